fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL set the byte address of the first fetch after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 redirect_valid  input  1  SHALL mean branch/jump taken this cycle (PCSel).
REQ-005 redirect_addr  input  32  SHALL be the redirect target byte address; bits [1:0] are ignored and treated as 0.
REQ-006 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-007 imem_addr  output  32  SHALL be the word-aligned byte address of the request.
REQ-008 imem_gnt  input  1  SHALL mean the memory accepted the request this cycle.
REQ-009 imem_rvalid  input  1  SHALL mean imem_rdata holds read data; asserted at least 1 cycle after imem_gnt.
REQ-010 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-011 inst_valid  output  1  SHALL mean inst/inst_pc hold an instruction for decode.
REQ-012 inst  output  32  SHALL be the buffered instruction.
REQ-013 inst_pc  output  32  SHALL be the byte address of inst.
REQ-014 inst_ready  input  1  SHALL mean decode consumes inst this cycle when inst_valid=1.
REQ-015 pc  output  32  SHALL be the current fetch address register.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD, plus 1-bit drop flag; one request outstanding maximum.
REQ-017 IDLE SHALL go to REQ on the first rising edge after rst deasserts.
REQ-018 imem_req SHALL equal (state==REQ); imem_addr SHALL equal pc at all times.
REQ-019 REQ: imem_gnt=1 -> WAIT; else remain REQ, imem_req held high.
REQ-020 WAIT: imem_rvalid=1 and drop=0 -> inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
REQ-021 On REQ-020 capture, next state SHALL be REQ if the buffer is empty or being consumed that cycle, else HOLD; with empty buffer that means the next request issues the cycle after rvalid.
REQ-022 HOLD: inst_ready=1 -> inst_valid<=0, state REQ; else hold all outputs stable.
REQ-023 inst_valid=1 and inst_ready=1 with no new capture SHALL clear inst_valid next cycle; inst/inst_pc SHALL not change while inst_valid=1 and inst_ready=0.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-025 redirect_valid=1 in any non-IDLE state SHALL: pc<=redirect_addr&~3, inst_valid<=0, and take precedence over capture and inst_ready.
REQ-026 Redirect in REQ without gnt: state stays REQ, address changes next cycle.
REQ-027 Redirect in REQ with imem_gnt=1, or in WAIT without rvalid: state WAIT, drop<=1.
REQ-028 Redirect in WAIT with imem_rvalid=1: response discarded, state REQ, drop<=0.
REQ-029 WAIT with drop=1 and imem_rvalid=1: data discarded, drop<=0, state REQ, pc unchanged.
REQ-030 Redirect in HOLD: state REQ; redirect in IDLE SHALL be ignored.
REQ-031 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, drop=0, pc=RESET_PC, inst_valid=0, imem_req=0, inst=0, inst_pc=0, regardless of clk.
REQ-033 Reset mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after release SHALL be ignored (state IDLE/REQ).

Verification
REQ-034 Reset release, 1-cycle memory, inst_ready=1: imem_addr sequence 0x0,0x4,0x8; first inst_valid 3 cycles after release (IDLE,REQ,WAIT), with inst_pc=0x0.
REQ-035 inst_ready=0 after first capture: state HOLD, imem_req=0, inst/inst_pc stable for 5 cycles; inst_ready=1 -> next request to 0x4 the following cycle.
REQ-036 Redirect to 0x103 while WAIT for 0x8: returned word discarded, next imem_addr=0x100, inst_valid never shows pc 0x8.
REQ-037 Redirect same cycle as rvalid: no inst_valid for old pc, next imem_addr=redirect target.
REQ-038 RESET_PC=32'hFFFFFFFC: second fetch address 0x00000000.
REQ-039 rst=0 asserted between clock edges while WAIT: outputs reach reset values before next edge; stray rvalid afterward produces no inst_valid.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request feeding a one-entry instruction buffer for decode.
// Latency: first inst_valid 3 cycles after reset release with a 1-cycle memory; back-to-back fetches every 2 cycles.
// Backpressure: inst_ready low parks the buffer in HOLD (no new request) until decode consumes it.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        drop, drop_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] inst_pc_nxt;
    logic        inst_valid_nxt;
    logic [31:0] redirect_target;
    logic        buf_stuck;
    logic        unused_redirect_lsbs;

    // Byte offset within the word is meaningless for fetch, so targets are forced word aligned.
    assign redirect_target      = {redirect_addr[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_addr[1:0];

    // Buffer occupied and decode not taking it this cycle: a returning word has nowhere to go.
    assign buf_stuck = inst_valid & ~inst_ready;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // Next-state and datapath decisions; redirect always wins over capture and consumption.
    always_comb begin
        state_nxt      = state;
        drop_nxt       = drop;
        pc_nxt         = pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid & ~inst_ready;

        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    state_nxt = WAIT;
                end
                if (redirect_valid) begin
                    pc_nxt         = redirect_target;
                    inst_valid_nxt = 1'b0;
                    // A request accepted this very cycle fetched the old path; its data must be dropped.
                    drop_nxt       = imem_gnt;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt         = redirect_target;
                    inst_valid_nxt = 1'b0;
                    if (imem_rvalid) begin
                        state_nxt = REQ;
                        drop_nxt  = 1'b0;
                    end else begin
                        drop_nxt  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_nxt = REQ;
                    drop_nxt  = 1'b0;
                    // Stale responses are discarded; if the buffer is still full and untaken the
                    // word is discarded too and the same pc is fetched again, so nothing is lost
                    // and a held instruction is never overwritten.
                    if (!drop && !buf_stuck) begin
                        inst_nxt       = imem_rdata;
                        inst_pc_nxt    = pc;
                        inst_valid_nxt = 1'b1;
                        pc_nxt         = pc + 32'd4;
                        state_nxt      = inst_ready ? REQ : HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt         = redirect_target;
                    inst_valid_nxt = 1'b0;
                    state_nxt      = REQ;
                end else if (inst_ready) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and buffer registers; reset takes effect immediately, independent of the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            pc         <= RESET_PC;
            inst       <= 32'h0000_0000;
            inst_pc    <= 32'h0000_0000;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            drop       <= drop_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural memory, directed timing probes and a randomized instruction-stream scoreboard.
// Expected values come from the program-order model (sequential pcs restarted at each redirect) and from cycle probes.
// A negedge monitor compares probes and every decode handshake against queued expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_ready = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    logic        d2_imem_req;
    logic [31:0] d2_imem_addr;
    logic        d2_inst_valid;
    logic [31:0] d2_inst;
    logic [31:0] d2_inst_pc;
    logic [31:0] d2_pc;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc(pc)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(d2_imem_req), .imem_addr(d2_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(d2_inst_valid), .inst(d2_inst), .inst_pc(d2_inst_pc),
        .inst_ready(inst_ready), .pc(d2_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    typedef struct {
        int          c;
        int          kind;
        logic [31:0] exp;
    } probe_t;

    probe_t      probe_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_hs = 0;
    int          hs_base = 0;
    bit          fin_req = 1'b0;
    bit          fin_done = 1'b0;

    // Memory model knobs and state
    int          gnt_pct = 100;
    int          dly_lo = 1;
    int          dly_hi = 1;
    bit          stray_en = 1'b0;
    bit          stray_force = 1'b0;
    bit          busy = 1'b0;
    bit          prev_gnt = 1'b0;
    int          cnt = 0;
    logic [31:0] addr_l = 32'h0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] actual(int k);
        case (k)
            0:       return {31'b0, imem_req};
            1:       return imem_addr;
            2:       return {31'b0, inst_valid};
            3:       return inst;
            4:       return inst_pc;
            5:       return pc;
            6:       return d2_imem_addr;
            7:       return d2_pc;
            8:       return {31'b0, d2_inst_valid};
            9:       return d2_inst_pc;
            10:      return d2_inst;
            11:      return {31'b0, d2_imem_req};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            0:       return "imem_req";
            1:       return "imem_addr";
            2:       return "inst_valid";
            3:       return "inst";
            4:       return "inst_pc";
            5:       return "pc";
            6:       return "d2_imem_addr";
            7:       return "d2_pc";
            8:       return "d2_inst_valid";
            9:       return "d2_inst_pc";
            10:      return "d2_inst";
            11:      return "d2_imem_req";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: cycle probes first, then every decode handshake against the program-order stream.
    always @(negedge clk) begin
        probe_t      p;
        logic [31:0] a;
        logic [31:0] e;
        while (probe_q.size() > 0 && probe_q[0].c <= cyc) begin
            p = probe_q.pop_front();
            a = actual(p.kind);
            n_cmp++;
            if (a !== p.exp) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got %h, expected %h", kname(p.kind), p.c, a, p.exp);
            end
        end
        if (rst && inst_valid && inst_ready && !redirect_valid) begin
            n_hs++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL stream @cyc %0d: unexpected instruction pc %h", cyc, inst_pc);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc !== e || inst !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL stream @cyc %0d: got pc %h inst %h, expected pc %h inst %h",
                             cyc, inst_pc, inst, e, mem_word(e));
                end
            end
        end
        if (fin_req && !fin_done) begin
            fin_done = 1'b1;
            n_cmp++;
            if (n_hs - hs_base < 100) begin
                n_bad++;
                $display("FAIL progress: %0d instructions delivered in random run, expected at least 100",
                         n_hs - hs_base);
            end
        end
    end

    task automatic expect_at(int c, int k, logic [31:0] v);
        probe_t p;
        p.c    = c;
        p.kind = k;
        p.exp  = v;
        probe_q.push_back(p);
    endtask

    // Program order restarts at a word-aligned address
    task automatic reseg(logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 1600; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic do_redirect(logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        reseg({a[31:2], 2'b00});
    endtask

    // One clock: advance to just after the edge, clear pulses, run the memory model
    task automatic step();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (!rst) begin
            busy        = 1'b0;
            prev_gnt    = 1'b0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            if (prev_gnt) begin
                busy   = 1'b1;
                cnt    = int'($urandom_range(dly_hi, dly_lo));
                addr_l = prev_addr;
            end
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(addr_l);
                    busy        = 1'b0;
                end
            end else if (stray_force || (stray_en && $urandom_range(99, 0) < 10)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
            end
            imem_gnt  = imem_req && !busy && (int'($urandom_range(99, 0)) < gnt_pct);
            prev_gnt  = imem_gnt;
            prev_addr = imem_addr;
        end
    endtask

    // Reset for two cycles then release; returns the release cycle (DUT in IDLE during it)
    task automatic reset_release(input bit chk, output int c);
        rst        = 1'b0;
        inst_ready = 1'b1;
        gnt_pct    = 100;
        dly_lo     = 1;
        dly_hi     = 1;
        stray_en   = 1'b0;
        step();
        if (chk) begin
            expect_at(cyc, 0, 32'h0);
            expect_at(cyc, 2, 32'h0);
            expect_at(cyc, 3, 32'h0);
            expect_at(cyc, 4, 32'h0);
            expect_at(cyc, 5, 32'h0);
            expect_at(cyc, 7, 32'hFFFF_FFFC);
        end
        step();
        rst = 1'b1;
        reseg(32'h0);
        c = cyc;
        if (chk) expect_at(c, 0, 32'h0);
    endtask

    initial begin
        int c;

        // Reset state, then sequential fetch with a 1-cycle memory and decode always ready
        reset_release(1'b1, c);
        expect_at(c + 1, 0, 32'h1);
        expect_at(c + 1, 1, 32'h0);
        expect_at(c + 1, 6, 32'hFFFF_FFFC);
        expect_at(c + 1, 11, 32'h1);
        expect_at(c + 2, 0, 32'h0);
        expect_at(c + 2, 2, 32'h0);
        expect_at(c + 3, 2, 32'h1);
        expect_at(c + 3, 4, 32'h0);
        expect_at(c + 3, 3, mem_word(32'h0));
        expect_at(c + 3, 1, 32'h4);
        expect_at(c + 3, 6, 32'h0);
        expect_at(c + 3, 8, 32'h1);
        expect_at(c + 3, 9, 32'hFFFF_FFFC);
        expect_at(c + 3, 10, mem_word(32'h0));
        expect_at(c + 5, 1, 32'h8);
        expect_at(c + 5, 0, 32'h1);
        expect_at(c + 5, 5, 32'h8);
        repeat (8) step();

        // Decode stalls on the first instruction: HOLD for five cycles, then fetch of 0x4
        reset_release(1'b0, c);
        inst_ready = 1'b0;
        expect_at(c + 2, 2, 32'h0);
        expect_at(c + 3, 2, 32'h1);
        expect_at(c + 3, 0, 32'h0);
        expect_at(c + 3, 4, 32'h0);
        expect_at(c + 3, 3, mem_word(32'h0));
        expect_at(c + 3, 1, 32'h4);
        expect_at(c + 7, 2, 32'h1);
        expect_at(c + 7, 0, 32'h0);
        expect_at(c + 7, 4, 32'h0);
        expect_at(c + 7, 3, mem_word(32'h0));
        expect_at(c + 8, 0, 32'h1);
        expect_at(c + 8, 1, 32'h4);
        expect_at(c + 8, 2, 32'h0);
        for (int k = 1; k <= 7; k++) step();
        inst_ready = 1'b1;
        repeat (6) step();

        // Redirect to 0x103 while waiting on the slow response for 0x8
        reset_release(1'b0, c);
        repeat (5) step();
        dly_lo = 3;
        dly_hi = 3;
        step();
        do_redirect(32'h0000_0103);
        dly_lo = 1;
        dly_hi = 1;
        expect_at(c + 6, 0, 32'h0);
        expect_at(c + 7, 5, 32'h100);
        expect_at(c + 7, 2, 32'h0);
        expect_at(c + 8, 2, 32'h0);
        expect_at(c + 8, 0, 32'h0);
        expect_at(c + 9, 0, 32'h1);
        expect_at(c + 9, 1, 32'h100);
        expect_at(c + 9, 2, 32'h0);
        expect_at(c + 10, 2, 32'h0);
        expect_at(c + 11, 2, 32'h1);
        expect_at(c + 11, 4, 32'h100);
        expect_at(c + 11, 3, mem_word(32'h100));
        repeat (8) step();

        // Redirect in the same cycle the response arrives
        reset_release(1'b0, c);
        repeat (2) step();
        do_redirect(32'h0000_0200);
        expect_at(c + 3, 0, 32'h1);
        expect_at(c + 3, 1, 32'h200);
        expect_at(c + 3, 2, 32'h0);
        expect_at(c + 4, 2, 32'h0);
        expect_at(c + 5, 2, 32'h1);
        expect_at(c + 5, 4, 32'h200);
        repeat (6) step();

        // Reset asserted between edges while waiting, then stray responses after release
        reset_release(1'b0, c);
        repeat (3) step();
        inst_ready = 1'b0;
        dly_lo = 3;
        dly_hi = 3;
        expect_at(c + 3, 2, 32'h1);
        expect_at(c + 3, 1, 32'h4);
        step();
        expect_at(c + 4, 2, 32'h0);
        expect_at(c + 4, 5, 32'h0);
        expect_at(c + 4, 4, 32'h0);
        expect_at(c + 4, 3, 32'h0);
        expect_at(c + 4, 1, 32'h0);
        expect_at(c + 4, 6, 32'hFFFF_FFFC);
        #2;
        rst = 1'b0;
        step();
        rst         = 1'b1;
        inst_ready  = 1'b1;
        dly_lo      = 1;
        dly_hi      = 1;
        reseg(32'h0);
        gnt_pct     = 0;
        stray_force = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        expect_at(c + 6, 2, 32'h0);
        expect_at(c + 6, 0, 32'h1);
        expect_at(c + 6, 1, 32'h0);
        expect_at(c + 7, 2, 32'h0);
        expect_at(c + 7, 0, 32'h1);
        expect_at(c + 10, 2, 32'h1);
        expect_at(c + 10, 4, 32'h0);
        repeat (2) step();
        gnt_pct     = 100;
        stray_force = 1'b0;
        repeat (5) step();

        // Randomized run: random grants, latencies, decode readiness, stray data and redirects
        reset_release(1'b0, c);
        hs_base = n_hs;
        for (int i = 0; i < 3000; i++) begin
            step();
            gnt_pct    = 50;
            dly_lo     = 1;
            dly_hi     = 3;
            stray_en   = 1'b1;
            inst_ready = ($urandom_range(99, 0) < 70);
            if (cyc > c && $urandom_range(99, 0) < 4) do_redirect($urandom);
        end
        fin_req = 1'b1;
        repeat (3) step();
        if (!fin_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL finish: monitor did not complete its final check");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
